// File: rtl/uart_rx.sv
// UART receiver: 8N1 framing, mid-bit sampling from a baud counter,
// two-flop input synchronizer, and a ready/overrun handshake with the consumer.
module uart_rx #(
    parameter int BAUD_DIV = 2604    // clocks per bit period (19200 baud at 50 MHz)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err,
    output logic       overrun,
    output logic       rx_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Start is checked half a bit in; data and stop bits are checked one full bit later.
    localparam logic [11:0] HALF_CNT = 12'(BAUD_DIV / 2 - 1);
    localparam logic [11:0] FULL_CNT = 12'(BAUD_DIV - 1);

    state_t      state, state_nxt;
    logic        rx_meta, rx_sync, rx_prev;
    logic [11:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg;
    logic        start_det;
    logic        cnt_clr;
    logic        shift_en;
    logic        stop_good;
    logic        stop_bad;

    // Synchronize RX into the clk domain and keep one extra delayed copy for edge detection.
    // NOTE: flops use non-blocking assignments so each stage sees the previous stage's old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // A 1->0 transition of the synchronized line; a line held low produces no second event.
    assign start_det = rx_prev & ~rx_sync;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic and per-cycle control strobes for the datapath.
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        stop_good = 1'b0;
        stop_bad  = 1'b0;
        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (start_det) state_nxt = START;
            end
            START: begin
                if (baud_cnt == HALF_CNT) begin
                    cnt_clr   = 1'b1;
                    // A high line mid-start-bit was a glitch: drop back silently.
                    state_nxt = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (baud_cnt == FULL_CNT) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) state_nxt = STOP;
                end
            end
            STOP: begin
                if (baud_cnt == FULL_CNT) begin
                    cnt_clr   = 1'b1;
                    stop_good = rx_sync;
                    stop_bad  = ~rx_sync;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Baud and bit counters plus the LSB-first shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            baud_cnt <= cnt_clr ? 12'd0 : baud_cnt + 12'd1;
            if (state == IDLE) bit_cnt <= 3'd0;
            else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
            if (shift_en) shift_reg <= {rx_sync, shift_reg[7:1]};
        end
    end

    // Consumer-facing outputs; a completing good frame takes priority over clr_rdy for rdy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data <= 8'h00;
            rdy     <= 1'b0;
            frm_err <= 1'b0;
            overrun <= 1'b0;
        end else begin
            frm_err <= stop_bad;
            if (clr_rdy) begin
                rdy     <= 1'b0;
                overrun <= 1'b0;
            end
            if (stop_good) begin
                rx_data <= shift_reg;
                rdy     <= 1'b1;
                // Only an unacknowledged previous byte counts as lost.
                if (rdy && !clr_rdy) overrun <= 1'b1;
            end
        end
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: stimulus pushes expected frame outcomes into a
// queue; a monitor on the falling clock edge pops and compares each DUT event.
module tb_uart_rx;

    localparam int BAUD = 16;                          // short bit time keeps the run small
    localparam int LAT  = BAUD / 2 + 9 * BAUD + 1;     // RX fall to rdy, nominal
    localparam int TOL  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       clr_rdy = 1'b0;
    logic [7:0] rx_data;
    logic       rdy, frm_err, overrun, rx_busy;

    uart_rx #(.BAUD_DIV(BAUD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (rx),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rdy     (rdy),
        .frm_err (frm_err),
        .overrun (overrun),
        .rx_busy (rx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_ferr;
        logic [7:0] data;
        bit         exp_rdy;
        bit         exp_ovr;
        int         fall;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   last_ev_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic check_window(input string name, input int act, input int lo, input int hi);
        n_total++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one 8N1 frame and register what the monitor should see at its end.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                              input logic [7:0] exp_data, input bit exp_rdy, input bit exp_ovr);
        exp_t e;
        e.is_ferr = !stop_bit;
        e.data    = exp_data;
        e.exp_rdy = exp_rdy;
        e.exp_ovr = exp_ovr;
        e.fall    = cyc;
        exp_q.push_back(e);
        rx = 1'b0;
        tick(BAUD);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(BAUD);
        end
        rx = stop_bit;
        tick(BAUD);
        rx = 1'b1;
    endtask

    task automatic pulse_clr();
        clr_rdy = 1'b1;
        tick(1);
        clr_rdy = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_data"}, rx_data, 8'h00);
        check({tag, "_rdy"}, rdy, 1'b0);
        check({tag, "_frm_err"}, frm_err, 1'b0);
        check({tag, "_overrun"}, overrun, 1'b0);
        check({tag, "_rx_busy"}, rx_busy, 1'b0);
    endtask

    // Monitor: any frm_err pulse, rdy rise or rx_data change is one DUT event.
    logic       prev_rdy = 1'b0;
    logic [7:0] prev_data = 8'h00;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (frm_err || (rdy && !prev_rdy) || (rx_data !== prev_data)) begin
                last_ev_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("spurious_event", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("ev_kind_ferr", frm_err, e.is_ferr);
                    check("ev_rx_data", rx_data, e.data);
                    check("ev_rdy", rdy, e.exp_rdy);
                    check("ev_overrun", overrun, e.exp_ovr);
                    check_window("ev_latency", cyc - e.fall, LAT - TOL, LAT + TOL);
                end
            end
        end
        prev_rdy  = rdy;
        prev_data = rx_data;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_clr;
        tick(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick(5);

        // False start: low for well under half a bit.
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        tick(40);
        check("false_start_busy", rx_busy, 1'b0);
        check("false_start_rdy", rdy, 1'b0);
        check("false_start_data", rx_data, 8'h00);

        // Bad stop bit: frm_err pulse, nothing else changes.
        send_frame(8'h3C, 1'b0, 8'h00, 1'b0, 1'b0);
        tick(20);
        check("ferr_after_frm_err", frm_err, 1'b0);
        check("ferr_after_rdy", rdy, 1'b0);
        check("ferr_after_data", rx_data, 8'h00);

        // Good frame; busy must be high mid-frame.
        fork
            send_frame(8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0);
            begin
                tick(3 * BAUD);
                check("busy_mid_frame", rx_busy, 1'b1);
            end
        join
        tick(10);
        pulse_clr();
        check("clr_rdy_a5", rdy, 1'b0);

        // Back-to-back with no acknowledge: overrun.
        send_frame(8'h11, 1'b1, 8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 8'h22, 1'b1, 1'b1);
        tick(2);
        check("ovr_flag", overrun, 1'b1);
        check("ovr_rdy", rdy, 1'b1);
        check("ovr_data", rx_data, 8'h22);
        pulse_clr();
        check("ovr_clr_rdy", rdy, 1'b0);
        check("ovr_clr_overrun", overrun, 1'b0);
        tick(10);

        // clr_rdy on the exact stop-sample cycle of the second frame.
        fork
            begin
                send_frame(8'h33, 1'b1, 8'h33, 1'b1, 1'b0);
                send_frame(8'h44, 1'b1, 8'h44, 1'b1, 1'b0);
            end
            begin
                tick(10 * BAUD);
                // Second frame's stop sample lands exactly one frame after the first.
                t_clr = last_ev_cyc + 10 * BAUD - 1;
                while (cyc < t_clr) tick(1);
                pulse_clr();
            end
        join
        tick(2);
        check("race_rdy", rdy, 1'b1);
        check("race_overrun", overrun, 1'b0);
        check("race_data", rx_data, 8'h44);
        pulse_clr();
        tick(10);

        // Reset during bit 4 of 0xFF, then a clean frame.
        rx = 1'b0;
        tick(BAUD);
        rx = 1'b1;
        tick(4 * BAUD + BAUD / 2);
        rst_n = 1'b0;
        tick(3);
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        tick(10);
        check_reset_outputs("postrst");
        send_frame(8'h5A, 1'b1, 8'h5A, 1'b1, 1'b0);
        tick(20);
        check("final_data", rx_data, 8'h5A);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
